// File: rtl/pc_fetch.sv
// pc_fetch: fetch-stage PC register with exception/eret redirect, stalls, next-PC select and fetch address check
module pc_fetch #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        En_PC,
  input  logic        stall_md,
  input  logic        stall_eret,
  input  logic        IntReq,
  input  logic        ExcReq,
  input  logic        eret_D,
  input  logic [31:0] EPC,
  input  logic [31:0] PC_D,
  input  logic [31:0] Instr_D,
  input  logic [1:0]  NPCSel_D,
  input  logic        cmp_D,
  input  logic [31:0] rs_D,
  output logic [31:0] PC_F,
  output logic        AdEL_F,
  output logic        BorJ_F
);
  logic [31:0] pc_plus4, br_target, j_target, npc;
  assign pc_plus4  = PC_F + 32'd4;
  assign br_target = PC_D + 32'd4 + {{14{Instr_D[15]}}, Instr_D[15:0], 2'b00};
  assign j_target  = {PC_D[31:28], Instr_D[25:0], 2'b00};
  always_comb begin
    npc = NPCSel_D == 2'b00 ? pc_plus4 :
          NPCSel_D == 2'b01 ? (cmp_D ? br_target : pc_plus4) :
          NPCSel_D == 2'b10 ? j_target : rs_D;
  end
  always_ff @(posedge clk) begin
    if (reset) PC_F <= PC_RESET;
    else if (IntReq | ExcReq) PC_F <= EXC_ENTRY;
    else if (stall_eret) PC_F <= PC_F;
    else if (eret_D) PC_F <= EPC;
    else if (!En_PC | stall_md) PC_F <= PC_F;
    else PC_F <= npc;
  end
  assign AdEL_F = |PC_F[1:0] | (PC_F < IM_LO) | (PC_F > IM_HI);
  assign BorJ_F = !eret_D & (NPCSel_D != 2'b00) & (PC_D != 32'd0);
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter PC_RESET, 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry PC.
REQ-003 Parameter IM_LO, 32'h0000_3000, lowest legal fetch address (inclusive).
REQ-004 Parameter IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 En_PC  input  1  hazard-unit enable; 0 = hold PC (load-use/forward stall).
REQ-008 stall_md  input  1  mult/div busy stall; 1 = hold PC.
REQ-009 stall_eret  input  1  eret-hazard stall; 1 = hold PC, blocks eret redirect.
REQ-010 IntReq  input  1  interrupt taken this cycle.
REQ-011 ExcReq  input  1  exception taken this cycle.
REQ-012 eret_D  input  1  eret in decode stage.
REQ-013 EPC  input  32  return address from CP0.
REQ-014 PC_D  input  32  PC of decode-stage instruction.
REQ-015 Instr_D  input  32  decode-stage instruction word.
REQ-016 NPCSel_D  input  2  00 sequential, 01 branch, 10 j/jal, 11 jr/jalr.
REQ-017 cmp_D  input  1  branch condition true (meaningful only for NPCSel_D=01).
REQ-018 rs_D  input  32  forwarded rs value for jr/jalr.
REQ-019 PC_F  output  32  current fetch PC (registered).
REQ-020 AdEL_F  output  1  fetch address error for PC_F (combinational from PC_F).
REQ-021 BorJ_F  output  1  instruction at PC_F is a delay-slot instruction.

Function
REQ-022 PC register update priority, highest first: reset; IntReq|ExcReq; stall_eret; eret_D; (!En_PC | stall_md); normal next-PC.
REQ-023 IntReq|ExcReq: PC_F <= EXC_ENTRY regardless of any stall or eret_D.
REQ-024 stall_eret=1 (no reset/int/exc): PC_F holds.
REQ-025 eret_D=1, stall_eret=0: PC_F <= EPC, overriding En_PC, stall_md and NPCSel_D.
REQ-026 En_PC=0 or stall_md=1 (no higher event): PC_F holds.
REQ-027 Normal next-PC: NPCSel_D=00 -> PC_F+4.
REQ-028 NPCSel_D=01: cmp_D=1 -> PC_D+4+(sign_ext(Instr_D[15:0])<<2); cmp_D=0 -> PC_F+4.
REQ-029 NPCSel_D=10: {PC_D[31:28], Instr_D[25:0], 2'b00}.
REQ-030 NPCSel_D=11: rs_D unmodified (misalignment not masked).
REQ-031 All address arithmetic modulo 2^32; wrap-around not flagged separately.
REQ-032 AdEL_F=1 when PC_F[1:0]!=0 or PC_F<IM_LO or PC_F>IM_HI (unsigned); else 0.
REQ-033 BorJ_F=1 when NPCSel_D!=00 and PC_D!=0 (D-stage holds a branch/jump), else 0; independent of cmp_D.
REQ-034 BorJ_F forced 0 while eret_D=1.
REQ-035 Redirect is single-cycle: no pending/queued target; a held PC re-evaluates next-PC when stall releases.

Reset
REQ-036 reset=1 at clock edge: PC_F <= PC_RESET; overrides IntReq, ExcReq, eret_D, stalls.
REQ-037 After reset with PC_RESET legal: AdEL_F=0; BorJ_F follows inputs only.
REQ-038 Reset asserted mid-stall or mid-redirect: no prior state survives; first fetch after release is PC_RESET.

Verification
REQ-039 reset 1 cycle, then 3 cycles NPCSel_D=00, no stalls -> PC_F 0x3000, 0x3004, 0x3008, 0x300C.
REQ-040 PC_D=0x3010, Instr_D[15:0]=0xFFFC, NPCSel_D=01, cmp_D=1 -> next PC_F=0x3004; BorJ_F=1 same cycle; cmp_D=0 -> PC_F+4.
REQ-041 NPCSel_D=11, rs_D=0x3002 -> PC_F=0x3002, AdEL_F=1; rs_D=0x7000 -> AdEL_F=1; rs_D=0x6FFC -> AdEL_F=0.
REQ-042 En_PC=0 for 2 cycles with NPCSel_D=10 -> PC_F held; on En_PC=1 PC_F={PC_D[31:28],Instr_D[25:0],00}.
REQ-043 eret_D=1, EPC=0x3020, stall_md=1 -> PC_F=0x3020; same with stall_eret=1 -> PC_F held.
REQ-044 ExcReq=1 with eret_D=1, stall_eret=1 -> PC_F=0x4180; reset=1 same cycle -> PC_F=0x3000.
